// File: rtl/axi_arbiter_m2s_m3.sv
// Master-to-slave arbiter for one AXI slave port: AR/AW grant selection (round-robin or fixed)
// with W beats steered in AW-grant order through a small grant FIFO.
//
//  state   | meaning
//  RUN     | grant follows the combinational selection; re-arbitrates every cycle
//  WAIT    | grant latched until the granted master completes its address handshake
module axi_arbiter_m2s_m3 #(
  parameter int NUM         = 3,
  parameter int WFIFO_DEPTH = 4
) (
  input  logic           AXI_CLK,
  input  logic           AXI_RSTn,
  input  logic           arbiter_type,
  input  logic [NUM:0]   ARSELECT,
  input  logic [NUM:0]   ARVALID,
  input  logic [NUM:0]   ARREADY,
  output logic [NUM:0]   ARGRANT,
  input  logic [NUM:0]   AWSELECT,
  input  logic [NUM:0]   AWVALID,
  input  logic [NUM:0]   AWREADY,
  output logic [NUM:0]   AWGRANT,
  input  logic [NUM:0]   WVALID,
  input  logic [NUM:0]   WREADY,
  input  logic [NUM:0]   WLAST,
  output logic [NUM:0]   WGRANT
);

  localparam int PW = (NUM > 0) ? $clog2(NUM + 1) : 1;
  localparam int FW = $clog2(WFIFO_DEPTH);
  localparam int CW = FW + 1;

  typedef enum logic {ST_RUN, ST_WAIT} arb_state_e;

  function automatic logic [NUM:0] select_grant(input logic [NUM:0] req,
                                                input logic [PW-1:0] ptr,
                                                input logic fixed_pri);
    logic [NUM:0] g;
    int idx;
    g = '0;
    for (int k = 0; k <= NUM; k++) begin
      idx = fixed_pri ? k : (int'(ptr) + k) % (NUM + 1);
      if (g == '0 && req[idx]) g[idx] = 1'b1;
    end
    return g;
  endfunction

  function automatic logic [PW-1:0] next_ptr(input logic [NUM:0] g);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i <= NUM; i++)
      if (g[i]) p = (i == NUM) ? '0 : PW'(i + 1);
    return p;
  endfunction

  arb_state_e     ar_state, ar_state_nxt, aw_state, aw_state_nxt;
  logic [NUM:0]   ar_hold, ar_hold_nxt, aw_hold, aw_hold_nxt;
  logic [NUM:0]   ar_sel, aw_sel;
  logic [PW-1:0]  ar_ptr, aw_ptr;
  logic           ar_hs, aw_hs;

  logic [NUM:0]   wfifo_mem [WFIFO_DEPTH];
  logic [FW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  w_count;
  logic           w_full, w_empty, w_push, w_pop;

  assign ar_sel = select_grant(ARSELECT & ARVALID, ar_ptr, arbiter_type);
  assign aw_sel = select_grant(AWSELECT & AWVALID, aw_ptr, arbiter_type);

  // Grants are forced low while reset is asserted so nothing leaks through the RUN-state path.
  always_comb begin
    ar_state_nxt = ar_state;
    ar_hold_nxt  = ar_hold;
    ARGRANT      = (ar_state == ST_RUN) ? ar_sel : ar_hold;
    if (!AXI_RSTn) ARGRANT = '0;
    ar_hs = |(ARGRANT & ARVALID & ARREADY);
    case (ar_state)
      ST_RUN: begin
        if (ARGRANT != '0 && !ar_hs) begin
          ar_state_nxt = ST_WAIT;
          ar_hold_nxt  = ARGRANT;
        end
      end
      ST_WAIT: if (ar_hs) ar_state_nxt = ST_RUN;
      default: ar_state_nxt = ST_RUN;
    endcase
  end

  // A full W-order FIFO blocks new AW grants; WAIT is only entered when not full.
  always_comb begin
    aw_state_nxt = aw_state;
    aw_hold_nxt  = aw_hold;
    if (aw_state == ST_RUN) AWGRANT = w_full ? '0 : aw_sel;
    else                    AWGRANT = aw_hold;
    if (!AXI_RSTn) AWGRANT = '0;
    aw_hs = |(AWGRANT & AWVALID & AWREADY);
    case (aw_state)
      ST_RUN: begin
        if (AWGRANT != '0 && !aw_hs) begin
          aw_state_nxt = ST_WAIT;
          aw_hold_nxt  = AWGRANT;
        end
      end
      ST_WAIT: if (aw_hs) aw_state_nxt = ST_RUN;
      default: aw_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge AXI_CLK or negedge AXI_RSTn) begin
    if (!AXI_RSTn) begin
      ar_state <= ST_RUN;
      aw_state <= ST_RUN;
      ar_hold  <= '0;
      aw_hold  <= '0;
      ar_ptr   <= '0;
      aw_ptr   <= '0;
    end else begin
      ar_state <= ar_state_nxt;
      aw_state <= aw_state_nxt;
      ar_hold  <= ar_hold_nxt;
      aw_hold  <= aw_hold_nxt;
      if (ar_hs) ar_ptr <= next_ptr(ARGRANT);
      if (aw_hs) aw_ptr <= next_ptr(AWGRANT);
    end
  end

  assign w_full  = (w_count == CW'(WFIFO_DEPTH));
  assign w_empty = (w_count == '0);
  assign WGRANT  = w_empty ? '0 : wfifo_mem[rd_ptr];
  assign w_push  = aw_hs;
  assign w_pop   = |(WGRANT & WVALID & WREADY & WLAST);

  always_ff @(posedge AXI_CLK or negedge AXI_RSTn) begin
    if (!AXI_RSTn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      w_count <= '0;
      for (int i = 0; i < WFIFO_DEPTH; i++) wfifo_mem[i] <= '0;
    end else begin
      if (w_push) begin
        wfifo_mem[wr_ptr] <= AWGRANT;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (w_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   w_count <= w_count + 1'b1;
        2'b01:   w_count <= w_count - 1'b1;
        default: w_count <= w_count;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_arbiter_m2s_m3.sv
// Directed bench for axi_arbiter_m2s_m3: stimulus queues expected grants per cycle, a negedge
// monitor pops and compares them against ARGRANT/AWGRANT/WGRANT.
module tb_axi_arbiter_m2s_m3;

  logic       AXI_CLK = 1'b0;
  logic       AXI_RSTn;
  logic       arbiter_type;
  logic [3:0] ARSELECT, ARVALID, ARREADY, ARGRANT;
  logic [3:0] AWSELECT, AWVALID, AWREADY, AWGRANT;
  logic [3:0] WVALID, WREADY, WLAST, WGRANT;

  axi_arbiter_m2s_m3 #(.NUM(3), .WFIFO_DEPTH(4)) dut (
    .AXI_CLK(AXI_CLK), .AXI_RSTn(AXI_RSTn), .arbiter_type(arbiter_type),
    .ARSELECT(ARSELECT), .ARVALID(ARVALID), .ARREADY(ARREADY), .ARGRANT(ARGRANT),
    .AWSELECT(AWSELECT), .AWVALID(AWVALID), .AWREADY(AWREADY), .AWGRANT(AWGRANT),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WGRANT(WGRANT)
  );

  always #5 AXI_CLK = ~AXI_CLK;

  int cyc = 0;
  always @(posedge AXI_CLK) cyc++;

  int         exp_cyc[$];
  int         exp_ch[$];
  int         exp_tid[$];
  logic [3:0] exp_val[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         test_id  = 0;

  int         mon_ch, mon_tid;
  logic [3:0] mon_exp, mon_act;
  string      mon_name;

  task automatic exp_push(input int ch, input logic [3:0] v);
    exp_cyc.push_back(cyc);
    exp_ch.push_back(ch);
    exp_tid.push_back(test_id);
    exp_val.push_back(v);
  endtask

  task automatic step();
    @(posedge AXI_CLK);
    #1;
  endtask

  task automatic idle();
    ARSELECT = '0; ARVALID = '0; ARREADY = '0;
    AWSELECT = '0; AWVALID = '0; AWREADY = '0;
    WVALID = '0; WREADY = '0; WLAST = '0;
  endtask

  always @(negedge AXI_CLK) begin
    while (exp_cyc.size() > 0 && exp_cyc[0] == cyc) begin
      void'(exp_cyc.pop_front());
      mon_ch  = exp_ch.pop_front();
      mon_tid = exp_tid.pop_front();
      mon_exp = exp_val.pop_front();
      case (mon_ch)
        0:       begin mon_act = ARGRANT; mon_name = "ARGRANT"; end
        1:       begin mon_act = AWGRANT; mon_name = "AWGRANT"; end
        default: begin mon_act = WGRANT;  mon_name = "WGRANT";  end
      endcase
      n_checks++;
      if (mon_act === mon_exp) n_pass++;
      else $display("FAIL test%0d %s cycle %0d: got %b expected %b",
                    mon_tid, mon_name, cyc, mon_act, mon_exp);
    end
  end

  logic [3:0] rr_seq [5];

  initial begin
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    idle();
    arbiter_type = 1'b0;
    AXI_RSTn     = 1'b0;

    // reset: requests present but all grants held low
    test_id = 0;
    step(); ARSELECT = 4'hF; ARVALID = 4'hF; ARREADY = 4'hF;
    exp_push(0, 4'b0000); exp_push(1, 4'b0000); exp_push(2, 4'b0000);
    step(); idle(); AXI_RSTn = 1'b1;

    // 1: round-robin rotation with zero-wait handshakes
    test_id = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) begin ARSELECT = 4'hF; ARVALID = 4'hF; ARREADY = 4'hF; end
      exp_push(0, rr_seq[i]);
    end
    step(); idle();

    // 2: fixed priority, held grant survives a higher-priority request
    test_id = 2;
    step(); arbiter_type = 1'b1; ARSELECT = 4'hF; ARVALID = 4'b1110; exp_push(0, 4'b0010);
    step(); ARVALID = 4'b1111; exp_push(0, 4'b0010);
    step(); exp_push(0, 4'b0010);
    step(); ARREADY = 4'hF; exp_push(0, 4'b0010);
    step(); ARVALID = 4'b1101; exp_push(0, 4'b0001);
    step(); idle();

    // 3: W order follows AW order even when M1 presents W first
    test_id = 3;
    step(); AWSELECT = 4'hF; AWREADY = 4'hF; AWVALID = 4'b0100;
    exp_push(1, 4'b0100); exp_push(2, 4'b0000);
    step(); AWVALID = 4'b0010; WVALID = 4'b0010; WREADY = 4'hF;
    exp_push(1, 4'b0010); exp_push(2, 4'b0100);
    step(); AWVALID = '0; WVALID = 4'b0110; WLAST = 4'b0010; exp_push(2, 4'b0100);
    step(); WLAST = '0; exp_push(2, 4'b0100);
    step(); exp_push(2, 4'b0100);
    step(); WLAST = 4'b0100; exp_push(2, 4'b0100);
    step(); WVALID = 4'b0010; WLAST = '0; exp_push(2, 4'b0010);
    step(); exp_push(2, 4'b0010);
    step(); exp_push(2, 4'b0010);
    step(); WLAST = 4'b0010; exp_push(2, 4'b0010);
    step(); idle(); exp_push(2, 4'b0000);

    // 4: FIFO full blocks the fifth AW grant until a WLAST pop
    test_id = 4;
    step(); AWSELECT = 4'hF; AWREADY = 4'hF; AWVALID = 4'b0001; exp_push(1, 4'b0001);
    step(); exp_push(1, 4'b0001); exp_push(2, 4'b0001);
    step(); exp_push(1, 4'b0001);
    step(); exp_push(1, 4'b0001);
    step(); exp_push(1, 4'b0000);
    step(); WVALID = 4'b0001; WREADY = 4'hF; WLAST = 4'b0001;
    exp_push(1, 4'b0000); exp_push(2, 4'b0001);
    step(); WVALID = '0; WLAST = '0; exp_push(1, 4'b0001);
    step(); AWVALID = '0;

    // 6: reset mid-W burst and mid AW WAIT
    test_id = 6;
    step(); WVALID = 4'b0001; WREADY = 4'hF; WLAST = 4'b0001; exp_push(2, 4'b0001);
    step(); WLAST = '0; AWVALID = 4'b0010; AWREADY = '0;
    exp_push(1, 4'b0010); exp_push(2, 4'b0001);
    step(); exp_push(1, 4'b0010);
    step(); AXI_RSTn = 1'b0; ARSELECT = 4'hF; ARVALID = 4'hF;
    exp_push(0, 4'b0000); exp_push(1, 4'b0000); exp_push(2, 4'b0000);
    step(); AXI_RSTn = 1'b1; arbiter_type = 1'b0; ARREADY = 4'hF;
    AWSELECT = 4'hF; AWVALID = 4'hF; AWREADY = 4'hF;
    WVALID = 4'b0001; WLAST = '0; WREADY = 4'hF;
    exp_push(0, 4'b0001); exp_push(1, 4'b0001); exp_push(2, 4'b0000);
    step(); idle(); WVALID = 4'b0001; WLAST = 4'b0001; WREADY = 4'hF; exp_push(2, 4'b0001);
    step(); idle(); exp_push(2, 4'b0000);

    // 5: simultaneous push and pop at count 2
    test_id = 5;
    step(); arbiter_type = 1'b1; AWSELECT = 4'hF; AWREADY = 4'hF; AWVALID = 4'b0010;
    exp_push(1, 4'b0010);
    step(); AWVALID = 4'b0100; exp_push(1, 4'b0100); exp_push(2, 4'b0010);
    step(); AWVALID = 4'b1000; WVALID = 4'b0010; WREADY = 4'hF; WLAST = 4'b0010;
    exp_push(1, 4'b1000); exp_push(2, 4'b0010);
    step(); AWVALID = '0; WVALID = 4'b0100; WLAST = 4'b0100; exp_push(2, 4'b0100);
    step(); WVALID = 4'b1000; WLAST = 4'b1000; exp_push(2, 4'b1000);
    step(); idle(); exp_push(2, 4'b0000);

    step(); step();
    if (exp_cyc.size() != 0) begin
      $display("FAIL scoreboard: %0d expected grants never compared, required 0", exp_cyc.size());
      n_checks += exp_cyc.size();
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
